// File: rtl/rtc_save_snapshot_pkg.sv
// Shared types and the snapshot word mux for the RTC save-file read path.
package rtc_save_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPARE = 2'd2,
    ST_HOLD    = 2'd3
  } snap_state_t;

  localparam int          RTC_WORD_COUNT = 5;
  localparam logic [15:0] RTC_FILL       = 16'hFFFF;

  localparam logic [7:0] WORD_TS_LO  = 8'd0;
  localparam logic [7:0] WORD_TS_HI  = 8'd1;
  localparam logic [7:0] WORD_ST_LO  = 8'd2;
  localparam logic [7:0] WORD_ST_MID = 8'd3;
  localparam logic [7:0] WORD_ST_HI  = 8'd4;

  // Snapshot layout is {timestamp[31:0], savedtime[47:0]}.
  function automatic logic [15:0] rtc_word_mux(input logic [7:0] idx, input logic [79:0] snap);
    logic [15:0] word;
    word = RTC_FILL;
    if (idx < 8'(RTC_WORD_COUNT)) begin
      case (idx)
        WORD_TS_LO:  word = snap[63:48];
        WORD_TS_HI:  word = snap[79:64];
        WORD_ST_LO:  word = snap[15:0];
        WORD_ST_MID: word = snap[31:16];
        WORD_ST_HI:  word = snap[47:32];
        default:     word = RTC_FILL;
      endcase
    end
    return word;
  endfunction

endpackage

// File: rtl/rtc_save_snapshot.sv
// Captures a tear-free {timestamp, savedtime} sample on the word-0 read of the
// RTC region and serves the five 16-bit save-file words from that sample.
module rtc_save_snapshot
  import rtc_save_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        rd_en,
  input  logic [17:0] rd_addr,
  input  logic [17:0] save_size_bytes,
  input  logic [31:0] rtc_timestamp,
  input  logic [47:0] rtc_savedtime,
  input  logic        rtc_inuse,
  input  logic        snap_release,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        snap_busy,
  output logic        snap_torn
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  snap_state_t r_state;
  logic [79:0] r_snap;
  logic [RW-1:0] r_retry;
  logic [15:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_torn;

  logic [17:0] w_offset;
  logic [7:0]  w_word_idx;
  logic        w_in_region;
  logic        w_busy;
  logic        w_read;
  logic [79:0] w_live;
  logic        w_unused_offset_bits;

  assign w_in_region = (rd_addr >= save_size_bytes);
  assign w_offset    = rd_addr - save_size_bytes;
  assign w_word_idx  = w_offset[8:1];
  assign w_unused_offset_bits = &{1'b0, w_offset[17:9], w_offset[0]};
  assign w_live      = {rtc_timestamp, rtc_savedtime};
  assign w_busy      = (r_state == ST_CAPTURE) || (r_state == ST_COMPARE);
  // Reads arriving mid-capture are dropped; the unloader must not issue them.
  assign w_read      = rd_en && w_in_region && !w_busy;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_snap     <= '0;
      r_retry    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_torn     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_read) begin
            if (!rtc_inuse) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= RTC_FILL;
            end else if (w_word_idx == WORD_TS_LO) begin
              r_snap  <= w_live;
              r_retry <= '0;
              r_state <= ST_CAPTURE;
            end else begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= rtc_word_mux(w_word_idx, r_snap);
            end
          end
        end
        ST_CAPTURE: r_state <= ST_COMPARE;
        ST_COMPARE: begin
          // Retry budget exhausted: accept the last sample as-is so every
          // later word still agrees with the word 0 being returned now.
          if (w_live == r_snap) begin
            r_torn     <= 1'b0;
            r_state    <= ST_HOLD;
            r_rd_valid <= 1'b1;
            r_rd_data  <= rtc_word_mux(WORD_TS_LO, r_snap);
          end else if (r_retry == RW'(MAX_RETRY)) begin
            r_torn     <= 1'b1;
            r_state    <= ST_HOLD;
            r_rd_valid <= 1'b1;
            r_rd_data  <= rtc_word_mux(WORD_TS_LO, r_snap);
          end else begin
            r_snap  <= w_live;
            r_retry <= r_retry + 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_read) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= rtc_inuse ? rtc_word_mux(w_word_idx, r_snap) : RTC_FILL;
          end
          if ((w_read && (w_word_idx == WORD_ST_HI)) || snap_release) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign snap_busy = w_busy;
  assign snap_torn = r_torn;

endmodule

// File: tb/tb_rtc_save_snapshot.sv
// Directed bench for rtc_save_snapshot: word map, capture latency, retry/torn
// behaviour, HOLD semantics, release and asynchronous reset.
module tb_rtc_save_snapshot;

  logic        clk_sys;
  logic        reset_n;
  logic        rd_en;
  logic [17:0] rd_addr;
  logic [17:0] save_size_bytes;
  logic [31:0] rtc_timestamp;
  logic [47:0] rtc_savedtime;
  logic        rtc_inuse;
  logic        snap_release;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        snap_busy;
  logic        snap_torn;

  int errors = 0;
  int checks = 0;
  bit busy_seen = 1'b0;

  rtc_save_snapshot #(.MAX_RETRY(8)) dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .save_size_bytes (save_size_bytes),
    .rtc_timestamp   (rtc_timestamp),
    .rtc_savedtime   (rtc_savedtime),
    .rtc_inuse       (rtc_inuse),
    .snap_release    (snap_release),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .snap_busy       (snap_busy),
    .snap_torn       (snap_torn)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one read at posedge+1 and wait (bounded) for rd_valid.
  // 'bumps' increments the live timestamp once per waiting cycle.
  task automatic do_read(input logic [17:0] addr, input logic [15:0] exp_data,
                         input int exp_lat, input int bumps, input string name);
    int lat;
    int left;
    bit got;
    left    = bumps;
    rd_addr = addr;
    rd_en   = 1'b1;
    @(posedge clk_sys); #1;
    rd_en        = 1'b0;
    snap_release = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 20) begin
      if (snap_busy) busy_seen = 1'b1;
      if (rd_valid) begin
        got = 1'b1;
      end else begin
        if (left > 0) begin
          rtc_timestamp = rtc_timestamp + 32'd1;
          left--;
        end
        @(posedge clk_sys); #1;
        lat++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no rd_valid within 20 cycles, expected at +%0d", name, exp_lat);
    end else begin
      $display("read %s addr=%h data=%h lat=%0d torn=%0b", name, addr, rd_data, lat, snap_torn);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_data"}, 32'(rd_data), 32'(exp_data));
      @(posedge clk_sys); #1;
      check({name, "_pulse"}, 32'(rd_valid), 32'd0);
    end
  endtask

  task automatic no_read(input logic [17:0] addr, input string name);
    bit seen;
    seen    = 1'b0;
    rd_addr = addr;
    rd_en   = 1'b1;
    @(posedge clk_sys); #1;
    rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rd_valid || snap_busy) seen = 1'b1;
      @(posedge clk_sys); #1;
    end
    $display("read %s addr=%h ignored=%0b", name, addr, !seen);
    check({name, "_ignored"}, 32'(seen), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{18'h2000, 16'h5678, 3};
    vecs[1] = '{18'h2002, 16'h1234, 1};
    vecs[2] = '{18'h2004, 16'hCCCC, 1};
    vecs[3] = '{18'h2006, 16'hBBBB, 1};
    vecs[4] = '{18'h2008, 16'hAAAA, 1};

    reset_n         = 1'b0;
    rd_en           = 1'b0;
    rd_addr         = '0;
    save_size_bytes = 18'd8192;
    rtc_timestamp   = 32'h1234_5678;
    rtc_savedtime   = 48'hAAAA_BBBB_CCCC;
    rtc_inuse       = 1'b1;
    snap_release    = 1'b0;

    #12;
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_busy", 32'(snap_busy), 32'd0);
    check("reset_torn", 32'(snap_torn), 32'd0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    no_read(18'h1FFE, "below_region");

    for (int i = 0; i < 5; i++) begin
      do_read(vecs[i].addr, vecs[i].data, vecs[i].lat, 0, $sformatf("stable_w%0d", i));
      if (i == 0) check("stable_torn", 32'(snap_torn), 32'd0);
    end
    do_read(18'h200A, 16'hFFFF, 1, 0, "idle_w5");

    // HOLD returns the old sample; word 4 releases, next word 0 recaptures.
    do_read(18'h2000, 16'h5678, 3, 0, "hold_cap");
    rtc_timestamp = 32'h1234_5679;
    do_read(18'h2000, 16'h5678, 1, 0, "hold_reread");
    do_read(18'h2008, 16'hAAAA, 1, 0, "hold_w4");
    do_read(18'h2000, 16'h5679, 3, 0, "recapture");
    rtc_timestamp = 32'h1234_567A;
    snap_release  = 1'b1;
    do_read(18'h2002, 16'h1234, 1, 0, "release_w1");
    do_read(18'h2000, 16'h567A, 3, 0, "after_release");
    do_read(18'h2008, 16'hAAAA, 1, 0, "release_exit");

    rtc_timestamp = 32'h1234_0010;
    do_read(18'h2000, 16'h0011, 4, 1, "one_retry");
    check("one_retry_torn", 32'(snap_torn), 32'd0);
    do_read(18'h2008, 16'hAAAA, 1, 0, "one_retry_exit");

    // Timestamp moves every cycle across a 16-bit rollover.
    rtc_timestamp = 32'h0000_FFF8;
    do_read(18'h2000, 16'h0001, 11, 100, "spin_w0");
    check("spin_torn", 32'(snap_torn), 32'd1);
    do_read(18'h2002, 16'h0001, 1, 0, "spin_w1");
    do_read(18'h2008, 16'hAAAA, 1, 0, "spin_exit");

    rtc_inuse = 1'b0;
    busy_seen = 1'b0;
    do_read(18'h2000, 16'hFFFF, 1, 0, "noinuse_w0");
    do_read(18'h2004, 16'hFFFF, 1, 0, "noinuse_w2");
    check("noinuse_busy", 32'(busy_seen), 32'd0);
    rtc_inuse = 1'b1;

    // Reset while COMPARE is pending.
    rd_addr = 18'h2000;
    rd_en   = 1'b1;
    @(posedge clk_sys); #1;
    rd_en = 1'b0;
    @(posedge clk_sys); #1;
    check("midcap_busy", 32'(snap_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midcap_rst_data", 32'(rd_data), 32'd0);
    check("midcap_rst_valid", 32'(rd_valid), 32'd0);
    check("midcap_rst_busy", 32'(snap_busy), 32'd0);
    check("midcap_rst_torn", 32'(snap_torn), 32'd0);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    do_read(18'h2002, 16'h0000, 1, 0, "post_reset_w1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
